// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle: master drives request fields, slave drives the response.
interface apb_slave_mem_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [32:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory with fixed wait states.
// Setup-phase fields are captured once; the access phase only counts and completes.
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic           pclk,
    input  logic           preset,
    apb_slave_mem_if.slave apb
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic          write_q;
    logic          err_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic          setup_c;
    logic          mem_we_c;
    logic          ready_c;
    logic          addr_err_c;
    logic [AW-1:0] addr_idx_c;

    // Address decode of the live bus: misaligned, past the last word, or upper bank selected.
    always_comb begin
        addr_idx_c = apb.paddr[AW+1:2];
        addr_err_c = (apb.paddr[1:0] != 2'b00)
                   | (apb.paddr[31:2] >= 30'(DEPTH))
                   | apb.paddr[32];
    end

    // Next-state, wait counting and response generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        setup_c     = 1'b0;
        mem_we_c    = 1'b0;
        ready_c     = 1'b0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        case (state_q)
            IDLE: begin
                // psel with penable already high is not a valid setup and is ignored
                if (apb.psel && !apb.penable) begin
                    setup_c = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ready_c     = (cnt_q == WAIT_MAX);
                apb.pready  = ready_c;
                apb.pslverr = ready_c & err_q;
                if (apb.psel && apb.penable) begin
                    if (ready_c) begin
                        mem_we_c = write_q & ~err_q;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // master withdrew before completion: abort silently
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and setup-phase capture; read data is fetched at setup.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            apb.prdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup_c) begin
                idx_q      <= addr_idx_c;
                write_q    <= apb.pwrite;
                err_q      <= addr_err_c;
                wdata_q    <= apb.pwdata;
                apb.prdata <= (!apb.pwrite && !addr_err_c) ? mem_q[addr_idx_c] : '0;
            end
        end
    end

    // Register memory; written only on a clean, completed write.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[AW'(i)] <= RESET_VAL;
            end
        end else if (mem_we_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with 2 wait states, one with none.
module tb_apb_slave_mem;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] RST_V = 32'h1234_5678;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    logic        sel  [2];
    logic        en   [2];
    logic        wr   [2];
    logic [32:0] addr [2];
    logic [31:0] wdat [2];
    logic        rdy  [2];
    logic        serr [2];
    logic [31:0] rdat [2];

    apb_slave_mem_if bus_a();
    apb_slave_mem_if bus_b();

    assign bus_a.psel    = sel[0];
    assign bus_a.penable = en[0];
    assign bus_a.pwrite  = wr[0];
    assign bus_a.paddr   = addr[0];
    assign bus_a.pwdata  = wdat[0];
    assign rdy[0]        = bus_a.pready;
    assign serr[0]       = bus_a.pslverr;
    assign rdat[0]       = bus_a.prdata;

    assign bus_b.psel    = sel[1];
    assign bus_b.penable = en[1];
    assign bus_b.pwrite  = wr[1];
    assign bus_b.paddr   = addr[1];
    assign bus_b.pwdata  = wdat[1];
    assign rdy[1]        = bus_b.pready;
    assign serr[1]       = bus_b.pslverr;
    assign rdat[1]       = bus_b.prdata;

    apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .RESET_VAL(RST_V)) dut_a (
        .pclk(pclk), .preset(preset), .apb(bus_a));
    apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .RESET_VAL(RST_V)) dut_b (
        .pclk(pclk), .preset(preset), .apb(bus_b));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_done;

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // An address is bad if not word aligned or its word number lies past the memory.
    function automatic bit addr_bad(input logic [32:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: each transfer completes after WAIT+1 access cycles.
    bit          m_busy [2];
    int          m_n    [2];
    bit          m_err  [2];
    bit          m_wr   [2];
    int          m_idx  [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rd   [2];
    logic [31:0] mmem   [2][DEPTH];

    always @(posedge pclk) cyc++;

    always @(posedge pclk or posedge preset) begin
        for (int d = 0; d < 2; d++) begin
            if (preset) begin
                m_busy[d] = 1'b0;
                for (int j = 0; j < DEPTH; j++) mmem[d][j] = RST_V;
            end else if (!m_busy[d]) begin
                if (sel[d] && !en[d]) begin
                    m_busy[d] = 1'b1;
                    m_n[d]    = 0;
                    m_err[d]  = addr_bad(addr[d]);
                    m_wr[d]   = wr[d];
                    m_idx[d]  = int'(addr[d] / 4);
                    m_wd[d]   = wdat[d];
                    m_rd[d]   = (!wr[d] && !m_err[d]) ? mmem[d][m_idx[d]] : 32'h0;
                end
            end else if (sel[d] && en[d]) begin
                if (m_n[d] == wait_of(d)) begin
                    if (m_wr[d] && !m_err[d]) mmem[d][m_idx[d]] = m_wd[d];
                    m_busy[d] = 1'b0;
                end else begin
                    m_n[d]++;
                end
            end else begin
                m_busy[d] = 1'b0;
            end
        end
    end

    // Every cycle: response must match the model for both instances.
    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            logic exp_rdy;
            exp_rdy = m_busy[d] && (m_n[d] == wait_of(d));
            chk($sformatf("cyc pready[%0d]", d), 32'(rdy[d]), 32'(exp_rdy));
            chk($sformatf("cyc pslverr[%0d]", d), 32'(serr[d]), 32'(exp_rdy && m_err[d]));
            if (exp_rdy) chk($sformatf("cyc prdata[%0d]", d), rdat[d], m_rd[d]);
        end
    end

    task automatic drive(input int d, input logic s, input logic e, input logic w,
                         input logic [32:0] a, input logic [31:0] v);
        sel[d] = s; en[d] = e; wr[d] = w; addr[d] = a; wdat[d] = v;
    endtask

    // One APB transfer; request fields are scrambled during access to prove they are latched.
    task automatic xfer(input int d, input logic w, input logic [32:0] a, input logic [31:0] v,
                        input int abort_at, output logic [31:0] rd, output logic se,
                        output int ncyc);
        int n;
        n = 0; rd = '0; se = 1'b0; ncyc = -1;
        drive(d, 1'b1, 1'b0, w, a, v);
        @(posedge pclk); #1;
        drive(d, 1'b1, 1'b1, ~w, 33'h0_0000_001C, ~v);
        forever begin
            @(negedge pclk);
            n++;
            if (rdy[d]) begin
                rd = rdat[d]; se = serr[d]; ncyc = n; last_done = cyc;
                @(posedge pclk); #1;
                drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
                return;
            end
            if (n == abort_at) begin
                drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
                @(posedge pclk); #1;
                return;
            end
            if (n > 40) begin
                total++;
                $display("FAIL timeout[%0d]: no pready after %0d cycles, expected %0d", d, n, wait_of(d) + 1);
                drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
                @(posedge pclk); #1;
                return;
            end
        end
    endtask

    task automatic do_xfer(input string name, input int d, input logic w, input logic [32:0] a,
                           input logic [31:0] v, input logic [31:0] exp_rd, input logic exp_se);
        logic [31:0] rd;
        logic        se;
        int          nc;
        xfer(d, w, a, v, -1, rd, se, nc);
        chk({name, " prdata"}, rd, exp_rd);
        chk({name, " pslverr"}, 32'(se), 32'(exp_se));
        chk({name, " latency"}, nc, wait_of(d) + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        se;
        int          nc;
        int          d0;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 1'b0, '0, '0);

        // reset state
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("reset pready a", 32'(rdy[0]), 32'h0);
        chk("reset pslverr a", 32'(serr[0]), 32'h0);
        chk("reset prdata a", rdat[0], 32'h0);
        chk("reset prdata b", rdat[1], 32'h0);
        #1 preset = 1'b0;
        idle(1);

        // write then read, two wait states
        do_xfer("wr 0x10", 0, 1'b1, 33'h010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_xfer("rd 0x10", 0, 1'b0, 33'h010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        idle(1);

        // error responses; errored writes must not alias onto valid words
        do_xfer("wr 0x102", 0, 1'b1, 33'h102, 32'hBAD0_0001, 32'h0, 1'b1);
        do_xfer("wr 0x12", 0, 1'b1, 33'h012, 32'hBAD0_0002, 32'h0, 1'b1);
        do_xfer("wr bank", 0, 1'b1, 33'h1_0000_0010, 32'hBAD0_0003, 32'h0, 1'b1);
        do_xfer("rd 0x100", 0, 1'b0, 33'h100, 32'h0, 32'h0, 1'b1);
        do_xfer("rd bank", 0, 1'b0, 33'h1_0000_0000, 32'h0, 32'h0, 1'b1);
        do_xfer("rd 0x00", 0, 1'b0, 33'h000, 32'h0, RST_V, 1'b0);
        do_xfer("rd 0x10 kept", 0, 1'b0, 33'h010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        do_xfer("rd 0xFC", 0, 1'b0, 33'h0FC, 32'h0, RST_V, 1'b0);
        do_xfer("wr 0xFC", 0, 1'b1, 33'h0FC, 32'h0F0F_F0F0, 32'h0, 1'b0);
        do_xfer("rd 0xFC new", 0, 1'b0, 33'h0FC, 32'h0, 32'h0F0F_F0F0, 1'b0);
        idle(2);

        // back-to-back: the read setup follows the write completion directly
        do_xfer("b2b wr 0x04", 0, 1'b1, 33'h004, 32'h0000_0011, 32'h0, 1'b0);
        d0 = last_done;
        do_xfer("b2b rd 0x04", 0, 1'b0, 33'h004, 32'h0, 32'h0000_0011, 1'b0);
        chk("b2b spacing", last_done - d0, 4);
        idle(2);

        // abort after one access cycle
        xfer(0, 1'b1, 33'h008, 32'h0000_0055, 1, rd, se, nc);
        chk("abort no pready", nc, -1);
        idle(3);
        do_xfer("rd 0x08 after abort", 0, 1'b0, 33'h008, 32'h0, RST_V, 1'b0);
        idle(1);

        // asynchronous reset during the access phase of a write
        drive(0, 1'b1, 1'b0, 1'b1, 33'h00C, 32'h0000_0077);
        @(posedge pclk); #1;
        drive(0, 1'b1, 1'b1, 1'b1, 33'h00C, 32'h0000_0077);
        @(posedge pclk); #3;
        preset = 1'b1;
        #1;
        chk("mid-reset pready", 32'(rdy[0]), 32'h0);
        chk("mid-reset pslverr", 32'(serr[0]), 32'h0);
        chk("mid-reset prdata", rdat[0], 32'h0);
        @(negedge pclk); #1;
        preset = 1'b0;
        // psel with penable high from IDLE must be ignored
        idle(2);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(1);
        do_xfer("rd 0x0C after reset", 0, 1'b0, 33'h00C, 32'h0, RST_V, 1'b0);
        do_xfer("rd 0x10 after reset", 0, 1'b0, 33'h010, 32'h0, RST_V, 1'b0);

        // zero wait states
        do_xfer("b rd 0x00", 1, 1'b0, 33'h000, 32'h0, RST_V, 1'b0);
        do_xfer("b wr 0x3C", 1, 1'b1, 33'h03C, 32'hCAFE_F00D, 32'h0, 1'b0);
        do_xfer("b rd 0x3C", 1, 1'b0, 33'h03C, 32'h0, 32'hCAFE_F00D, 1'b0);
        do_xfer("b rd 0x101", 1, 1'b0, 33'h101, 32'h0, 32'h0, 1'b1);
        do_xfer("b b2b wr 0x20", 1, 1'b1, 33'h020, 32'h0000_0005, 32'h0, 1'b0);
        d0 = last_done;
        do_xfer("b b2b rd 0x20", 1, 1'b0, 33'h020, 32'h0, 32'h0000_0005, 1'b0);
        chk("b b2b spacing", last_done - d0, 2);
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
